// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared constants and state encoding for the pattern sender and detector
package seq_pkg;

    localparam int TIMER_W   = 8;
    localparam int PATTERN_W = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_HIGH = S_HIGH,
        ST_GAP  = S_GAP,
        ST_DONE = S_DONE
    } state_t;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - single-cycle rising-edge detector on a level input
module rise_detect (
    input  logic clk,     // posedge clock
    input  logic rst_n,   // synchronous active-low reset
    input  logic d,       // level input
    output logic rise     // high while d=1 and the previous sample was 0
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    // d_q clears in reset, so a level held through reset release reads as an edge.
    assign rise = d & ~d_q;

endmodule

// File: rtl/seq_pattern_sender.sv
// rtl/seq_pattern_sender.sv - replays a 4-bit pattern MSB first as pulse_a(1)/pulse_b(0) pulses
module seq_pattern_sender
    import seq_pkg::*;
#(
    parameter int HIGH_CYCLES = 4,             // cycles each pulse is high, 1..255
    parameter int GAP_CYCLES  = 4              // cycles both lines low after a pulse, 1..255
) (
    input  logic                 clk,          // posedge clock
    input  logic                 rst_n,        // synchronous active-low reset
    input  logic                 start,        // button level, rising edge starts a frame
    input  logic [PATTERN_W-1:0] pattern,      // captured on the accepted start edge
    output logic                 pulse_a,      // high during a '1' bit pulse
    output logic                 pulse_b,      // high during a '0' bit pulse
    output logic                 busy,         // high in HIGH and GAP
    output logic                 done,         // one-cycle strobe after the last gap
    output logic [1:0]           bit_idx       // bit currently being sent, 3 down to 0
);

    localparam logic [TIMER_W-1:0] HIGH_RELOAD = TIMER_W'(HIGH_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_RELOAD  = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);
    localparam logic [1:0]         IDX_FIRST   = 2'(PATTERN_W - 1);

    state_t               state;
    state_t               state_nx;
    logic [PATTERN_W-1:0] shreg;
    logic [TIMER_W-1:0]   timer;
    logic                 start_rise;
    logic                 timer_zero;
    logic                 load_frame;
    logic                 load_high;
    logic                 load_gap;

    rise_detect u_start_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (start),
        .rise  (start_rise)
    );

    assign timer_zero = (timer == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Outputs depend only on registered state/datapath, never on inputs directly.
    always_comb begin
        state_nx   = state;
        load_frame = 1'b0;
        load_high  = 1'b0;
        load_gap   = 1'b0;
        pulse_a    = 1'b0;
        pulse_b    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                // Edges outside IDLE are dropped, not queued.
                if (start_rise) begin
                    state_nx   = ST_HIGH;
                    load_frame = 1'b1;
                end
            end
            ST_HIGH: begin
                busy    = 1'b1;
                pulse_a = shreg[bit_idx];
                pulse_b = ~shreg[bit_idx];
                if (timer_zero) begin
                    state_nx = ST_GAP;
                    load_gap = 1'b1;
                end
            end
            ST_GAP: begin
                busy = 1'b1;
                if (timer_zero) begin
                    if (bit_idx != 2'd0) begin
                        state_nx  = ST_HIGH;
                        load_high = 1'b1;
                    end else begin
                        state_nx = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Timer reloads at zero, so the plain decrement can never wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_idx <= 2'd0;
            timer   <= '0;
        end else if (load_frame) begin
            shreg   <= pattern;
            bit_idx <= IDX_FIRST;
            timer   <= HIGH_RELOAD;
        end else if (load_gap) begin
            timer <= GAP_RELOAD;
        end else if (load_high) begin
            timer   <= HIGH_RELOAD;
            bit_idx <= bit_idx - 2'd1;
        end else if (!timer_zero) begin
            timer <= timer - TIMER_ONE;
        end
    end

endmodule

// File: tb/tb_seq_pattern_sender.sv
// tb/tb_seq_pattern_sender.sv - scoreboard bench for seq_pattern_sender
module tb_seq_pattern_sender;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       start_f;
    logic [3:0] pattern;
    logic [3:0] pattern_f;
    logic       pulse_a, pulse_b, busy, done;
    logic [1:0] bit_idx;
    logic       pulse_a_f, pulse_b_f, busy_f, done_f;
    logic [1:0] bit_idx_f;

    always #5 clk = ~clk;

    seq_pattern_sender dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .pattern (pattern),
        .pulse_a (pulse_a),
        .pulse_b (pulse_b),
        .busy    (busy),
        .done    (done),
        .bit_idx (bit_idx)
    );

    seq_pattern_sender #(.HIGH_CYCLES(1), .GAP_CYCLES(1)) dut_f (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_f),
        .pattern (pattern_f),
        .pulse_a (pulse_a_f),
        .pulse_b (pulse_b_f),
        .busy    (busy_f),
        .done    (done_f),
        .bit_idx (bit_idx_f)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    typedef struct packed {
        logic       is_a;
        logic [1:0] idx;
    } exp_t;

    exp_t exp_q[$];
    logic mon_abort  = 1'b1;
    logic prev_pulse = 1'b0;
    logic prev_busy  = 1'b0;
    int   hi_len     = 0;
    int   busy_len   = 0;
    int   done_cnt   = 0;

    task automatic push_frame(input logic [3:0] p, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            exp_t e;
            e.is_a = p[3-i];
            e.idx  = 2'(3 - i);
            exp_q.push_back(e);
        end
    endtask

    // Monitor for the default-timing instance: pops one expectation per pulse.
    always @(negedge clk) begin
        exp_t e;
        if (mon_abort) begin
            prev_pulse = 1'b0;
            prev_busy  = 1'b0;
            hi_len     = 0;
            busy_len   = 0;
        end else begin
            chk("no_overlap", 32'(pulse_a & pulse_b), 32'(0));
            if (pulse_a | pulse_b) begin
                if (!prev_pulse) begin
                    chk("pulse_expected", 32'(exp_q.size() != 0), 32'(1));
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("pulse_line", 32'(pulse_a), 32'(e.is_a));
                        chk("pulse_bit_idx", 32'(bit_idx), 32'(e.idx));
                    end
                    hi_len = 1;
                end else begin
                    hi_len++;
                end
            end else if (prev_pulse) begin
                chk("pulse_high_len", 32'(hi_len), 32'(4));
            end
            if (busy) begin
                busy_len++;
            end else if (prev_busy) begin
                chk("busy_len", 32'(busy_len), 32'(32));
                chk("done_after_busy", 32'(done), 32'(1));
                busy_len = 0;
            end
            if (done) done_cnt++;
            prev_pulse = pulse_a | pulse_b;
            prev_busy  = busy;
        end
    end

    // Loopback detector model: one bit per rising pulse edge, sampled on negedge.
    logic [3:0] det_hist = 4'b0000;
    logic       pa_q = 1'b0;
    logic       pb_q = 1'b0;
    always @(negedge clk) begin
        if (pulse_a && !pa_q) det_hist <= {det_hist[2:0], 1'b1};
        if (pulse_b && !pb_q) det_hist <= {det_hist[2:0], 1'b0};
        pa_q <= pulse_a;
        pb_q <= pulse_b;
    end

    task automatic press(input logic [3:0] p);
        pattern = p;
        start   = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("done_count", 32'(done_cnt), 32'(target));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        start_f   = 1'b0;
        pattern   = 4'b0000;
        pattern_f = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pulse_a", 32'(pulse_a), 32'(0));
        chk("rst_pulse_b", 32'(pulse_b), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_bit_idx", 32'(bit_idx), 32'(0));
        chk("rst_fast_busy", 32'(busy_f), 32'(0));
        mon_abort = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Frame 1011 with default timing
        push_frame(4'b1011, 4);
        press(4'b1011);
        chk("f1_busy_first", 32'(busy), 32'(1));
        chk("f1_pulse_a_first", 32'(pulse_a), 32'(1));
        chk("f1_bit_idx_first", 32'(bit_idx), 32'(3));
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1, 60);
        chk("f1_idle_busy", 32'(busy), 32'(0));
        chk("f1_idle_done", 32'(done), 32'(0));
        chk("f1_queue_empty", 32'(exp_q.size()), 32'(0));
        chk("det_1011", 32'(det_hist == 4'b1011), 32'(1));

        // Re-press at cycle 10 with a pattern change mid-frame
        @(posedge clk);
        #1;
        push_frame(4'b1001, 4);
        press(4'b1001);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        start   = 1'b1;
        pattern = 4'b0110;
        wait_done(2, 60);
        repeat (40) @(posedge clk);
        #1;
        chk("repress_no_second_done", 32'(done_cnt), 32'(2));
        chk("repress_busy", 32'(busy), 32'(0));
        chk("repress_queue_empty", 32'(exp_q.size()), 32'(0));
        start = 1'b0;
        @(posedge clk);
        #1;
        push_frame(4'b0110, 4);
        press(4'b0110);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(3, 60);
        chk("f0110_queue_empty", 32'(exp_q.size()), 32'(0));
        chk("det_0110", 32'(det_hist == 4'b1011), 32'(0));

        // Reset at cycle 13 of a frame; start held through reset release
        @(posedge clk);
        #1;
        push_frame(4'b1100, 2);
        press(4'b1100);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        mon_abort = 1'b1;
        chk("midrst_pulse_a", 32'(pulse_a), 32'(0));
        chk("midrst_pulse_b", 32'(pulse_b), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_done", 32'(done), 32'(0));
        chk("midrst_bit_idx", 32'(bit_idx), 32'(0));
        start   = 1'b1;
        pattern = 4'b0101;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_stays_idle", 32'(busy), 32'(0));
        chk("midrst_queue_consumed", 32'(exp_q.size()), 32'(0));
        mon_abort = 1'b0;
        push_frame(4'b0101, 4);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("release_held_start_busy", 32'(busy), 32'(1));
        chk("release_held_start_idx", 32'(bit_idx), 32'(3));
        start = 1'b0;
        wait_done(4, 60);
        chk("f0101_queue_empty", 32'(exp_q.size()), 32'(0));

        // Start held high for 100 cycles
        @(posedge clk);
        #1;
        push_frame(4'b1010, 4);
        press(4'b1010);
        repeat (99) @(posedge clk);
        #1;
        start = 1'b0;
        chk("held_one_done", 32'(done_cnt), 32'(5));
        chk("held_busy", 32'(busy), 32'(0));
        chk("held_queue_empty", 32'(exp_q.size()), 32'(0));
        chk("det_1010", 32'(det_hist == 4'b1011), 32'(0));

        // H=1, G=1 instance with pattern 0000
        pattern_f = 4'b0000;
        start_f   = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 8; k++) begin
            chk("fast_busy", 32'(busy_f), 32'(1));
            chk("fast_pulse_b", 32'(pulse_b_f), 32'(k % 2));
            chk("fast_pulse_a", 32'(pulse_a_f), 32'(0));
            @(posedge clk);
            #1;
        end
        chk("fast_done", 32'(done_f), 32'(1));
        chk("fast_busy_end", 32'(busy_f), 32'(0));
        @(posedge clk);
        #1;
        chk("fast_done_one_cycle", 32'(done_f), 32'(0));
        start_f = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
